// File: rtl/bram_stream_reader.sv
// Burst reader for a 2-cycle-latency RAM read port: issues sequential reads from
// base for len words and streams them out through a 4-entry buffer with valid/ready.
module bram_stream_reader #(
  parameter int ADDR_ = 8,
  parameter int DATA_ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDR_-1:0] base,
  input  logic [ADDR_:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ADDR_-1:0] raddr,
  input  logic [DATA_-1:0] rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DATA_-1:0] m_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEPTH = 4;

  state_e           state_q, state_d;
  logic [ADDR_-1:0] raddr_q, raddr_d;
  logic [ADDR_:0]   rem_q, rem_d;
  logic [1:0]       vld_q, vld_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [DATA_-1:0] fifo_q [DEPTH];

  logic [3:0] occ;
  logic       issue;
  logic       capture;
  logic       pop;

  // Occupancy covers words still in the RAM pipeline, so the buffer can never overflow.
  assign occ     = 4'(vld_q[0]) + 4'(vld_q[1]) + 4'(cnt_q);
  assign issue   = (state_q == RUN) && (occ < 4'(DEPTH));
  assign capture = vld_q[1];
  assign pop     = m_valid && m_ready;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign raddr   = raddr_q;
  assign m_valid = (cnt_q != 3'd0);
  assign m_data  = m_valid ? fifo_q[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    raddr_d  = raddr_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    vld_d    = {vld_q[0], issue};
    wr_ptr_d = capture ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    cnt_d    = cnt_q + 3'(capture) - 3'(pop);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            raddr_d = base;
            rem_d   = len;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue) begin
          raddr_d = raddr_q + ADDR_'(1);
          rem_d   = rem_q - (ADDR_+1)'(1);
          if (rem_q == (ADDR_+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the edge that empties both the pipeline and the buffer.
        if ((vld_d == 2'b00) && (cnt_d == 3'd0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      raddr_q  <= '0;
      rem_q    <= '0;
      vld_q    <= 2'b00;
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      rem_q    <= rem_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // NOTE: buffer storage is not reset; the count gates every read so stale entries are invisible.
  always_ff @(posedge clk) begin
    if (capture) fifo_q[wr_ptr_q] <= rdata;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter ADDR_, default 8, meaning RAM address width in bits.
REQ-002 SHALL have parameter DATA_, default 8, meaning RAM data width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a burst read.
REQ-006 SHALL have port base, input, ADDR_, the first word address, sampled with start.
REQ-007 SHALL have port len, input, ADDR_+1, the word count (0..2^ADDR_), sampled with start.
REQ-008 SHALL have port busy, output, 1, high while a burst is active.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when a burst completes.
REQ-010 SHALL have port raddr, output, ADDR_, the read address to the RAM read port.
REQ-011 SHALL have port rdata, input, DATA_, the RAM read data, valid exactly 2 cycles after raddr.
REQ-012 SHALL have port m_valid, output, 1, stream data valid.
REQ-013 SHALL have port m_ready, input, 1, stream sink ready.
REQ-014 SHALL have port m_data, output, DATA_, stream data word.

Function
REQ-015 SHALL model the RAM read latency as follows: raddr presented in cycle N yields rdata in cycle N+2; the RAM read port has no enable.
REQ-016 SHALL use three states.
- IDLE: busy=0.
- RUN: issuing reads.
- DRAIN: all reads issued; waiting for in-flight reads to return and the buffer to empty.
REQ-017 SHALL act on start only in IDLE.
- len>0: latch base and len, go to RUN.
- len=0: stay in IDLE and pulse done in the next cycle.
REQ-018 SHALL ignore start while busy=1.
REQ-019 SHALL issue a read in a cycle only when both hold:
- state is RUN;
- occupancy < 4, where occupancy = in-flight reads + words held in the output buffer.
REQ-020 SHALL advance raddr by 1 on each issued read, modulo 2^ADDR_ (wrap from 2^ADDR_-1 to 0).
REQ-021 SHALL hold raddr at its last value when no read is issued.
REQ-022 SHALL track in-flight reads with a 2-stage valid shift register aligned to the RAM latency.
REQ-023 SHALL capture rdata into a 4-entry output FIFO at the end of the cycle in which that returned word is valid.
REQ-024 SHALL drive m_valid from FIFO not-empty and m_data from the FIFO head.
- First word: m_valid earliest in cycle N+3 after its issue in cycle N.
REQ-025 SHALL pop the FIFO on m_valid && m_ready.
REQ-026 SHALL keep m_data stable while m_valid=1 && m_ready=0.
REQ-027 SHALL handle a capture and a pop in the same cycle as follows: both take effect and the occupancy count is unchanged.
REQ-028 SHALL sustain one word per cycle when m_ready is held at 1.
REQ-029 SHALL never overflow the FIFO; the occupancy limit of 4 guarantees this under arbitrary m_ready.
REQ-030 SHALL move from RUN to DRAIN in the cycle after the len-th read is issued.
REQ-031 SHALL move from DRAIN to IDLE when in-flight = 0 and the FIFO is empty, and pulse done in that same transition cycle.
REQ-032 SHALL deliver words in address order, exactly len words per burst, with no duplicates or drops.
REQ-033 SHALL accept a new start in the cycle after done.

Reset
REQ-034 SHALL, on rst=1 (asynchronously), clear the following:
- state -> IDLE;
- busy, done, m_valid -> 0;
- raddr, m_data -> 0;
- FIFO pointers, occupancy and the in-flight shift register -> 0.
REQ-035 SHALL, on rst asserted mid-burst, discard all in-flight reads and buffered words and emit no done pulse.
REQ-036 SHALL, after rst deasserts, ignore any rdata still returning from pre-reset reads.

Verification
REQ-037 SHALL be verified by these directed scenarios, each against a 2-cycle-latency RAM model where mem[i]=i:
- Basic: ADDR_=8; start with base=0x10, len=4; m_ready=1 -> m_data 0x10,0x11,0x12,0x13 on 4 consecutive cycles; the first occurs 4 cycles after start; done pulses once.
- Wrap: base=0xFE, len=4 -> raddr sequence FE,FF,00,01; data in the same order.
- Backpressure: len=16 with m_ready=0 for 10 cycles, then 1 -> at most 4 reads outstanding; m_data held stable while stalled; all 16 words delivered in order.
- Zero length and busy start: start with len=0 -> no read, busy stays 0, done pulses the next cycle; a start while busy -> ignored, the burst is unaltered.
- Reset mid-burst: rst asserted after 3 reads issued -> m_valid=0 immediately with no done pulse; a new burst with base=0x40, len=2 -> 0x40,0x41 only.
- Random m_ready: len=256 (full wrap) -> 256 words in order, and done follows the last pop.
